// File: rtl/up_counter_hex_display.sv
// up_counter_hex_display: debounced push-button up-counter with a
// loadable saturating limit and two active-low hex digit displays.
module up_counter_hex_display #(
  parameter int unsigned N               = 6,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         load,
  input  logic [N-1:0] num,
  output logic [N-1:0] count,
  output logic         done,
  output logic [6:0]   segA,
  output logic [6:0]   segB
);

  localparam int unsigned SW = $clog2(DEBOUNCE_CYCLES + 1);
  // The level flips on the edge that would take stab to DEBOUNCE_CYCLES.
  localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE_CYCLES - 16'd1);

  logic          inc_m_q;
  logic          inc_s_q;
  logic [SW-1:0] stab_q;
  logic [SW-1:0] stab_d;
  logic          inc_db_q;
  logic          inc_db_d;
  logic          inc_db_dly_q;
  logic          press;
  logic [N-1:0]  count_q;
  logic [N-1:0]  count_d;
  logic [N-1:0]  limit_q;
  logic [N-1:0]  limit_d;
  logic          done_q;
  logic          done_d;
  logic [3:0]    lo_nib;
  logic [3:0]    hi_nib;

  // Two-flop synchroniser for the raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_m_q <= 1'b0;
      inc_s_q <= 1'b0;
    end else begin
      inc_m_q <= inc;
      inc_s_q <= inc_m_q;
    end
  end

  // Count consecutive cycles the synced input disagrees with the
  // accepted level; accept it once it has held long enough.
  always_comb begin
    stab_d   = '0;
    inc_db_d = inc_db_q;
    if (inc_s_q != inc_db_q) begin
      if (stab_q == STAB_LAST) begin
        inc_db_d = inc_s_q;
      end else begin
        stab_d = stab_q + SW'(1);
      end
    end
  end

  // Debounce state and the delayed level used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_q       <= '0;
      inc_db_q     <= 1'b0;
      inc_db_dly_q <= 1'b0;
    end else begin
      stab_q       <= stab_d;
      inc_db_q     <= inc_db_d;
      inc_db_dly_q <= inc_db_q;
    end
  end

  assign press = inc_db_q & ~inc_db_dly_q;

  // Load beats press; a press at the limit saturates instead of wrapping.
  always_comb begin
    limit_d = limit_q;
    count_d = count_q;
    if (load) begin
      limit_d = num;
      count_d = '0;
    end else if (press && (count_q < limit_q)) begin
      count_d = count_q + N'(1);
    end
    done_d = (count_d == limit_d);
  end

  // Counter, limit and done are all registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      limit_q <= '1;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
      done_q  <= done_d;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      4'hF:    s = 7'b0111000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign lo_nib = count_q[3:0];
  assign hi_nib = 4'(count_q >> 4);

  // Display digits follow the registered count combinationally.
  always_comb begin
    segA = hex7(lo_nib);
    segB = hex7(hi_nib);
  end

  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_up_counter_hex_display.sv
// tb_up_counter_hex_display: directed and random stimulus checked
// against a windowed-history reference model of the counter.
module tb_up_counter_hex_display;

  localparam int N = 6;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         inc;
  logic         load;
  logic [N-1:0] num;
  logic [N-1:0] count;
  logic         done;
  logic [6:0]   segA;
  logic [6:0]   segB;

  int n_vec = 0;
  int n_bad = 0;

  logic [6:0] seg_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Raw button samples, newest first.
  bit hist [D+2];
  bit m_db;
  bit m_rose;
  int m_count;
  int m_limit;
  bit m_done;

  always #5 clk = ~clk;

  up_counter_hex_display #(
    .N(N),
    .DEBOUNCE_CYCLES(16'(D))
  ) dut (
    .clk(clk),
    .rst(rst),
    .inc(inc),
    .load(load),
    .num(num),
    .count(count),
    .done(done),
    .segA(segA),
    .segB(segB)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D + 2; i++) hist[i] = 1'b0;
    m_db    = 1'b0;
    m_rose  = 1'b0;
    m_count = 0;
    m_limit = (1 << N) - 1;
    m_done  = 1'b0;
  endtask

  // A button level is accepted once the synced stream (two samples
  // behind the raw input) has shown the opposite level D times running.
  // The press it creates reaches the count one edge later.
  task automatic model_edge(input bit r, input bit ld, input int nm);
    bit all;
    if (ld) begin
      m_limit = nm;
      m_count = 0;
    end else if (m_rose && m_count < m_limit) begin
      m_count = m_count + 1;
    end
    m_done = (m_count == m_limit);
    for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = r;
    all = 1'b1;
    for (int i = 2; i <= D + 1; i++) begin
      if (hist[i] == m_db) all = 1'b0;
    end
    m_rose = 1'b0;
    if (all) begin
      m_db   = ~m_db;
      m_rose = m_db;
    end
  endtask

  task automatic compare_all();
    chk("count", 32'(count), 32'(m_count));
    chk("done", 32'(done), 32'(m_done));
    chk("segA", 32'(segA), 32'(seg_tbl[m_count % 16]));
    chk("segB", 32'(segB), 32'(seg_tbl[m_count / 16]));
  endtask

  task automatic step(input bit i, input bit ld = 1'b0,
                      input int nm = 0);
    inc  = i;
    load = ld;
    num  = N'(nm);
    @(posedge clk);
    model_edge(i, ld, nm);
    #1;
    compare_all();
  endtask

  task automatic press_once();
    repeat (8) step(1'b1);
    repeat (8) step(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_segA", 32'(segA), 32'b0000001);
    chk("rst_segB", 32'(segB), 32'b0000001);
    @(posedge clk);
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  int exp1 [5] = '{1, 2, 3, 3, 3};
  bit lvl;
  int len;
  bit ld;
  int nm;

  initial begin
    rst  = 1'b1;
    inc  = 1'b0;
    load = 1'b0;
    num  = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Limit 3, five clean presses.
    step(1'b0, 1'b1, 3);
    for (int p = 0; p < 5; p++) begin
      press_once();
      chk("t1_count", 32'(count), 32'(exp1[p]));
      chk("t1_done", 32'(done), 32'(p >= 2));
    end
    chk("t1_segA", 32'(segA), 32'b0000110);
    chk("t1_segB", 32'(segB), 32'b0000001);

    // Held button: count moves exactly on edge D+3, only once.
    step(1'b0, 1'b1, 63);
    repeat (8) step(1'b0);
    for (int e = 1; e <= 7; e++) begin
      step(1'b1);
      chk("t2_latency", 32'(count), 32'(e == 7));
    end
    repeat (100) step(1'b1);
    chk("t2_hold", 32'(count), 32'd1);
    repeat (8) step(1'b0);

    // Bounce shorter than the debounce window.
    for (int c = 0; c < 20; c++) step(1'((c / 2) % 2 == 0));
    repeat (10) step(1'b0);
    chk("t3_bounce", 32'(count), 32'd1);

    // Full range up to saturation at 63.
    step(1'b0, 1'b1, 63);
    repeat (26) press_once();
    chk("t4_count26", 32'(count), 32'd26);
    chk("t4_segA", 32'(segA), 32'b0001000);
    chk("t4_segB", 32'(segB), 32'b1001111);
    repeat (37) press_once();
    chk("t4_count63", 32'(count), 32'd63);
    chk("t4_done", 32'(done), 32'd1);
    press_once();
    chk("t4_sat", 32'(count), 32'd63);

    // Load and press on the same edge: load wins.
    step(1'b0, 1'b1, 20);
    repeat (5) press_once();
    chk("t5_pre", 32'(count), 32'd5);
    repeat (6) step(1'b1);
    step(1'b1, 1'b1, 10);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    repeat (4) step(1'b1);
    repeat (8) step(1'b0);
    chk("t5_after", 32'(count), 32'd0);
    press_once();
    chk("t5_next", 32'(count), 32'd1);

    // Zero limit: done immediately, presses ignored.
    step(1'b0, 1'b1, 0);
    chk("t0_done", 32'(done), 32'd1);
    press_once();
    chk("t0_count", 32'(count), 32'd0);

    // Reset in the middle of a debounce with the button held.
    step(1'b0, 1'b1, 20);
    repeat (12) press_once();
    chk("t6_pre", 32'(count), 32'd12);
    repeat (3) step(1'b1);
    inc = 1'b1;
    do_reset();
    for (int e = 1; e <= 7; e++) begin
      step(1'b1);
      chk("t6_release", 32'(count), 32'(e == 7));
    end
    repeat (8) step(1'b0);

    // Random runs of button levels with occasional loads.
    for (int c = 0; c < 2500; ) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) begin
        ld = ($urandom_range(0, 39) == 0);
        nm = $urandom_range(0, 63);
        step(lvl, ld, nm);
        c++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
